// File: rtl/hazard_scoreboard.sv
// Forwarding and load-use stall controller that sits beside the ID stage.
// It tracks the destination of every in-flight instruction past ID and picks the youngest producer for each operand.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int RA_W     = 5,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_wraddr,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic             stall,
  output logic [15:0]      stall_cnt
);

  // Entry k holds the instruction k+1 stages past ID (0 = EXE).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_en_q, wr_en_d;
  logic [DEPTH-1:0] load_q,  load_d;
  logic [RA_W-1:0]  wraddr_q [DEPTH];
  logic [RA_W-1:0]  wraddr_d [DEPTH];
  logic [15:0]      cnt_q, cnt_d;

  logic [DEPTH-1:0] match_a, match_b;
  logic             haz_a, haz_b;
  logic [SEL_W-1:0] sel_a, sel_b;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k] = id_rs_used && valid_q[k] && wr_en_q[k] &&
                   (wraddr_q[k] == id_rs) && (id_rs != '0);
      match_b[k] = id_rt_used && valid_q[k] && wr_en_q[k] &&
                   (wraddr_q[k] == id_rt) && (id_rt != '0);
    end
  end

  // Scanning from oldest to youngest lets the youngest match overwrite the rest.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        sel_a = SEL_W'(k + 1);
        haz_a = load_q[k] && (k < LOAD_LAT);
      end
      if (match_b[k]) begin
        sel_b = SEL_W'(k + 1);
        haz_b = load_q[k] && (k < LOAD_LAT);
      end
    end
  end

  assign fwd_a     = sel_a;
  assign fwd_b     = sel_b;
  assign stall     = id_valid && (haz_a || haz_b) && !flush;
  assign stall_cnt = cnt_q;

  // Downstream stages never stall, so the tracker always shifts.
  always_comb begin
    valid_d[0]  = id_valid && !stall && !flush;
    wr_en_d[0]  = id_wr_en;
    load_d[0]   = id_is_load;
    wraddr_d[0] = id_wraddr;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k]  = valid_q[k-1];
      wr_en_d[k]  = wr_en_q[k-1];
      load_d[k]   = load_q[k-1];
      wraddr_d[k] = wraddr_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wr_en_q <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wraddr_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wr_en_q <= wr_en_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        wraddr_q[k] <= wraddr_d[k];
      end
    end
  end

endmodule
